game_tick_generator: RTL
========================

Name: game_tick_generator

Overview:
- Parametrised game timing source for the snake core and the time/score display; runs on clock_25.
- Produces single-cycle move_tick pulses whose period shortens with difficulty level, and single-cycle sec_tick pulses at exactly 1 s.
- Keeps an elapsed-seconds counter with start/pause/stop control.
- Replaces free-running MSB-derived square waves with exact, programmable, glitch-free periods.

Parameters:
- SEC_DIV, 25_000_000: clock_25 cycles per sec_tick (exactly 1.000 s).
- MOVE_BASE, 12_500_000: move period in cycles at level 0.
- MOVE_STEP, 2_500_000: period reduction per level.
- MOVE_MIN, 2_500_000: lower clamp on move period.
- CNT_W, 25: width of the period counters. It must hold max(SEC_DIV, MOVE_BASE) - 1.
- LEVEL_W, 2: width of the level input.
- SEC_MAX, 999: saturation value of elapsed_sec.
- SEC_W, 10: width of elapsed_sec.

Ports:
- clock_25  in  1  system clock, 25 MHz.
- reset  in  1  asynchronous, active-low; clears everything.
- sync_reset  in  1  synchronous clear, active-high; same effect as reset at the next edge.
- start  in  1  level; 1 = game running, 0 = stop and clear.
- pause  in  1  level; 1 = freeze counters while started.
- level  in  LEVEL_W  difficulty level, 0 = slowest.
- move_tick  out  1  one-cycle pulse each move period.
- sec_tick  out  1  one-cycle pulse each second.
- elapsed_sec  out  SEC_W  seconds elapsed while running; saturates at SEC_MAX.
- running  out  1  high in RUN state.

Behaviour:
- Reset values: state IDLE, both counters 0, period register = MOVE_BASE, all outputs 0.
- Reset priority, highest first: reset (async) > sync_reset > start=0 > pause > normal counting.
- Effect of start=0: at the next edge, state goes to IDLE, counters and elapsed_sec clear to 0, ticks are 0. This applies from any state.
- State machine:
  - IDLE -> RUN when start=1 and pause=0.
  - IDLE -> PAUSED when start=1 and pause=1.
  - RUN -> PAUSED when pause=1.
  - PAUSED -> RUN when pause=0.
  - Any state -> IDLE when start=0 or sync_reset=1.
- Period computation:
  - move_period = max(MOVE_BASE - level*MOVE_STEP, MOVE_MIN).
  - Compute at CNT_W+LEVEL_W bits, no underflow; clamp before truncation.
- Period latching:
  - Latch move_period into the period register on IDLE exit.
  - Re-latch it on every move-counter wrap.
  - A level change mid-period takes effect at the next wrap only, so no short or long glitch period occurs.
- Counting in RUN, each edge:
  - If cnt == P-1: cnt <= 0 and tick <= 1.
  - Otherwise: cnt <= cnt+1 and tick <= 0.
  - Ticks are registered outputs, high for exactly one cycle.
- First tick timing:
  - The first RUN cycle has cnt=0.
  - The first move_tick is high in the P-th cycle after entering RUN; each subsequent one follows P cycles later.
  - sec_tick follows the same rule with SEC_DIV.
- PAUSED:
  - Both counters and elapsed_sec hold; ticks forced to 0.
  - Resume continues from the held count, so no partial period is lost.
- Pause asserted on the edge where cnt == P-1: the pause wins. No tick is issued and cnt holds at P-1. The tick fires on the first RUN edge after resume.
- elapsed_sec:
  - Increments on the same edge that sets sec_tick.
  - At SEC_MAX it holds; sec_tick still pulses.
- running = (state == RUN), registered.
- move_tick and sec_tick are independent: simultaneous pulses are allowed.

Decomposition:
- Shared package game_timing_pkg holds:
  - state encoding: IDLE=2'd0, RUN=2'd1, PAUSED=2'd2;
  - default constants: CLK_HZ=25_000_000, SEC_DIV, MOVE_BASE, MOVE_STEP, MOVE_MIN.
- Sub-module tick_prescaler: programmable-period counter with ports clk, rst_n, clr, en, period, tick, wrap_load. It is instantiated twice: once for move timing, once for seconds.
- The top level holds the FSM, the period computation/clamp, and elapsed_sec.

Test Plan:
All scenarios use small parameters: SEC_DIV=10, MOVE_BASE=8, MOVE_STEP=2, MOVE_MIN=3, SEC_MAX=3.
1. start=1, level=0, pause=0 from reset -> move_tick high in cycles 8, 16, 24 after RUN entry. sec_tick high in cycles 10, 20. elapsed_sec = 1, then 2. running=1 from the first edge.
2. Level 0 -> 3 changed at cycle 4 -> the current period completes at cycle 8. Subsequent move_ticks come every 3 cycles (8-6=2, clamped to 3): cycles 11, 14.
3. pause=1 for 5 cycles, asserted at cycle 7 (cnt=7=P-1) -> no tick at cycle 8. The tick comes on the first RUN edge after release; counters are frozen while paused. elapsed_sec is unchanged.
4. Run 50 cycles -> elapsed_sec saturates at 3, and sec_tick still pulses every 10 cycles.
5. sync_reset=1 pulse mid-run, start held 1 -> next edge: counters 0, elapsed_sec 0, state IDLE. The edge after: RUN, and the timing of scenario 1 repeats.
6. reset=0 asserted asynchronously between edges -> all outputs 0 immediately. start=0 mid-run -> IDLE and cleared at the next edge.

Source files
------------

// File: rtl/game_timing_pkg.sv
// rtl/game_timing_pkg.sv - shared state encoding and default timing constants
package game_timing_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } game_state_e;

  localparam int CLK_HZ    = 25_000_000;
  localparam int SEC_DIV   = CLK_HZ;
  localparam int MOVE_BASE = 12_500_000;
  localparam int MOVE_STEP = 2_500_000;
  localparam int MOVE_MIN  = 2_500_000;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - programmable-period counter emitting a registered one-cycle tick
module tick_prescaler #(
  parameter int CNT_W = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  output logic             tick,
  output logic             wrap_load
);

  logic [CNT_W-1:0] cnt_q;
  logic             tick_q;
  logic             at_end;

  // Last count of the period; wrap_load tells the owner this edge wraps so it can re-latch the period.
  assign at_end    = (cnt_q == period - CNT_W'(1));
  assign wrap_load = en & ~clr & at_end;
  assign tick      = tick_q;

  // Count only while enabled; holding (en=0) freezes the count and suppresses the tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (clr) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (en) begin
      cnt_q  <= at_end ? '0 : cnt_q + CNT_W'(1);
      tick_q <= at_end;
    end else begin
      tick_q <= 1'b0;
    end
  end

endmodule

// File: rtl/game_tick_generator.sv
// rtl/game_tick_generator.sv - move/second tick source with run/pause FSM and elapsed-seconds count
module game_tick_generator
  import game_timing_pkg::*;
#(
  parameter int SEC_DIV   = game_timing_pkg::SEC_DIV,
  parameter int MOVE_BASE = game_timing_pkg::MOVE_BASE,
  parameter int MOVE_STEP = game_timing_pkg::MOVE_STEP,
  parameter int MOVE_MIN  = game_timing_pkg::MOVE_MIN,
  parameter int CNT_W     = 25,
  parameter int LEVEL_W   = 2,
  parameter int SEC_MAX   = 999,
  parameter int SEC_W     = 10
) (
  input  logic               clock_25,
  input  logic               reset,
  input  logic               sync_reset,
  input  logic               start,
  input  logic               pause,
  input  logic [LEVEL_W-1:0] level,
  output logic               move_tick,
  output logic               sec_tick,
  output logic [SEC_W-1:0]   elapsed_sec,
  output logic               running
);

  localparam int PW = CNT_W + LEVEL_W;

  game_state_e      state_q;
  logic             running_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] period_d;
  logic [SEC_W-1:0] elapsed_q;
  logic [PW-1:0]    step_w;
  logic [PW-1:0]    base_w;
  logic [PW-1:0]    min_w;
  logic [PW-1:0]    move_period_w;
  logic             clr;
  logic             run_en;
  logic             idle_exit;
  logic             move_wrap;
  logic             sec_wrap;

  // Clear has priority over pause; counting only happens on edges that stay in RUN.
  assign clr       = sync_reset | ~start;
  assign run_en    = (state_q == RUN) & ~clr & ~pause;
  assign idle_exit = (state_q == IDLE) & ~clr;

  assign step_w = PW'(level) * PW'(MOVE_STEP);
  assign base_w = PW'(MOVE_BASE);
  assign min_w  = PW'(MOVE_MIN);

  // Shorten the move period with level at full width, clamping to the minimum before truncation.
  always_comb begin
    move_period_w = min_w;
    if ((step_w < base_w) && ((base_w - step_w) > min_w)) begin
      move_period_w = base_w - step_w;
    end
  end

  assign period_d = CNT_W'(move_period_w);

  // Run/pause state machine with registered running flag.
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
    end else if (clr) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, RUN, PAUSED: begin
          state_q   <= pause ? PAUSED : RUN;
          running_q <= ~pause;
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  // Move period only changes at game start or a wrap, so level changes never cut a period short.
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      period_q <= CNT_W'(MOVE_BASE);
    end else if (sync_reset) begin
      period_q <= CNT_W'(MOVE_BASE);
    end else if (idle_exit | move_wrap) begin
      period_q <= period_d;
    end
  end

  // Elapsed seconds advance with each second wrap and stick at the maximum.
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      elapsed_q <= '0;
    end else if (clr) begin
      elapsed_q <= '0;
    end else if (sec_wrap && (elapsed_q != SEC_W'(SEC_MAX))) begin
      elapsed_q <= elapsed_q + SEC_W'(1);
    end
  end

  tick_prescaler #(
    .CNT_W(CNT_W)
  ) u_move_prescaler (
    .clk       (clock_25),
    .rst_n     (reset),
    .clr       (clr),
    .en        (run_en),
    .period    (period_q),
    .tick      (move_tick),
    .wrap_load (move_wrap)
  );

  tick_prescaler #(
    .CNT_W(CNT_W)
  ) u_sec_prescaler (
    .clk       (clock_25),
    .rst_n     (reset),
    .clr       (clr),
    .en        (run_en),
    .period    (CNT_W'(SEC_DIV)),
    .tick      (sec_tick),
    .wrap_load (sec_wrap)
  );

  assign elapsed_sec = elapsed_q;
  assign running     = running_q;

endmodule
